// File: rtl/conv_stream_ctrl.sv
// rtl/conv_stream_ctrl.sv - frame controller for the four-lane 3x3 convolver
// Owns the double-buffered kernel, input gating, prime-discard tagging and the output FIFO.
module conv_stream_ctrl #(
    parameter int NB_DATA     = 32,
    parameter int NB_COEFF    = 8,
    parameter int KERNEL_SIZE = 9,
    parameter int FRAME_WORDS = 600,
    parameter int PRIME_WORDS = 100,
    parameter int PIPE_LAT    = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic                            i_kernel_wr,
    input  logic [3:0]                      i_kernel_addr,
    input  logic [NB_COEFF-1:0]             i_kernel_data,
    output logic [NB_COEFF*KERNEL_SIZE-1:0] o_kernel,
    input  logic [NB_DATA-1:0]              s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [NB_DATA-1:0]              o_sub_data,
    output logic                            o_sub_valid,
    input  logic [NB_DATA-1:0]              i_conv_data,
    output logic [NB_DATA-1:0]              m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            o_busy,
    output logic                            o_done
);
    localparam int KW   = NB_COEFF * KERNEL_SIZE;
    localparam int CW   = $clog2(FRAME_WORDS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
    localparam logic [KW-1:0] IDENT =
        KW'({(NB_COEFF-1){1'b1}}) << (NB_COEFF * (KERNEL_SIZE / 2));

    typedef enum logic [1:0] {IDLE, COMMIT, STREAM, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       word_q, word_d;
    logic [PIPE_LAT-1:0] tag_q, tag_d;
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NW-1:0]       count_q, count_d;
    logic [KW-1:0]       shadow_q, shadow_d, active_q, active_d;
    logic [NB_DATA-1:0]  mem_q [FIFO_DEPTH];
    logic [OW-1:0]       pending, occupancy;
    logic                accept, fifo_wr, fifo_rd, drained;

    always_comb begin
        pending = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            pending = pending + OW'(tag_q[i]);
        end
        occupancy   = OW'(count_q) + pending;
        // Reserve FIFO space for every kept word still in the datapath.
        s_ready     = (state_q == STREAM) && (occupancy < OW'(FIFO_DEPTH));
        accept      = s_valid && s_ready;
        o_sub_valid = accept;
        o_sub_data  = s_data;
        m_valid     = (count_q != '0);
        m_data      = m_valid ? mem_q[rptr_q] : '0;
        fifo_wr     = tag_q[PIPE_LAT-1];
        fifo_rd     = m_valid && m_ready;
        drained     = (tag_q == '0) && (count_q == '0);
        tag_d       = (tag_q << 1) | PIPE_LAT'(accept && (word_q >= CW'(PRIME_WORDS)));
        o_kernel    = active_q;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (fifo_wr) begin
            wptr_d = (wptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (fifo_rd) begin
            rptr_d = (rptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        active_d = active_q;
        shadow_d = shadow_q;
        o_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = COMMIT;
            end
            COMMIT: begin
                active_d = shadow_q;
                word_d   = '0;
                state_d  = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    word_d = word_q + 1'b1;
                    if (word_q == CW'(FRAME_WORDS - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    o_done  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Shadow write happens after the commit copy, so a same-cycle write waits a frame.
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            if (i_kernel_wr && (i_kernel_addr == 4'(k))) begin
                shadow_d[k*NB_COEFF +: NB_COEFF] = i_kernel_data;
            end
        end
        o_busy = (state_q != IDLE) && !o_done;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            tag_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            shadow_q <= IDENT;
            active_q <= IDENT;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            tag_q    <= tag_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_wr) mem_q[wptr_q] <= i_conv_data;
    end
endmodule

// File: doc/conv_stream_ctrl.md
# conv_stream_ctrl

Frame-level controller for the four-lane 3x3 convolver datapath (subframe buffer plus four conv_2d lanes). It owns the 72-bit kernel register set with double-buffered software loading, gates input words into the subframe with a valid/ready handshake, and discards the outputs produced while the line buffer primes. It collects lane results in an output FIFO sized to absorb the fixed datapath latency, so downstream back-pressure never drops a pixel.

## Interface
Parameters:
- NB_DATA, 32, input/output word width (4 pixels x 8 bits)
- NB_COEFF, 8, coefficient width
- KERNEL_SIZE, 9, coefficients per kernel (3x3)
- FRAME_WORDS, 600, input words per frame
- PRIME_WORDS, 100, leading input words whose results are discarded (line-buffer fill); must be less than FRAME_WORDS
- PIPE_LAT, 2, cycles from word accept (o_sub_valid) to result on i_conv_data
- FIFO_DEPTH, 8, output FIFO entries; must be at least PIPE_LAT+1

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle frame start request
- i_kernel_wr  in  1  coefficient write strobe
- i_kernel_addr  in  4  coefficient index k = row*3+col
- i_kernel_data  in  NB_COEFF  coefficient value
- o_kernel  out  NB_COEFF*KERNEL_SIZE  active kernel; bits [8k+7:8k] hold coefficient k
- s_data  in  NB_DATA  input pixel word
- s_valid  in  1  input word valid
- s_ready  out  1  controller accepts a word this cycle
- o_sub_data  out  NB_DATA  s_data passed through to the subframe
- o_sub_valid  out  1  s_valid & s_ready (subframe i_valid)
- i_conv_data  in  NB_DATA  concatenated lane outputs {pix0,pix1,pix2,pix3}
- m_data  out  NB_DATA  FIFO head
- m_valid  out  1  FIFO not empty
- m_ready  in  1  downstream accept
- o_busy  out  1  state is not IDLE
- o_done  out  1  one-cycle pulse at frame completion

## Operation
- State machine:
  - IDLE: i_start moves to COMMIT.
  - COMMIT (1 cycle): shadow kernel is copied to the active kernel; word counter is cleared; moves to STREAM.
  - STREAM: words are accepted. On the accept of word FRAME_WORDS-1, moves to DRAIN.
  - DRAIN: waits until the pipeline tag register and the FIFO are both empty, then pulses o_done and returns to IDLE.
- i_start outside IDLE is ignored.
- Kernel writes go to the shadow registers in any state. Addresses 9 to 15 are ignored.
  - A write in the same cycle as COMMIT is not part of the commit; it lands in the shadow for the next frame.
  - o_kernel changes only in COMMIT.
- s_ready = (state==STREAM) && (fifo_count + pending < FIFO_DEPTH). pending is the number of set bits in the tag shift register.
- Tag shift register, PIPE_LAT bits: on accept, the shifted-in bit is 1 when word index >= PRIME_WORDS, otherwise 0.
- When a 1 leaves the tag register, i_conv_data is written into the FIFO at that clock edge.
- FIFO read occurs when m_valid && m_ready. Simultaneous read and write keeps the count unchanged, and the write lands correctly even when the FIFO is full before the read.
- Results per frame: FRAME_WORDS - PRIME_WORDS, in input order.
- Counters are wide enough for FRAME_WORDS. The word counter never wraps within a frame.

## Timing
- Reset (asynchronous assert, synchronous release) produces:
  - state IDLE
  - s_ready=0, o_sub_valid=0, m_valid=0, m_data=0, o_busy=0, o_done=0
  - FIFO and tags cleared
  - active and shadow kernels set to identity: k=4 is 8'h7F, all others 8'h00
- Reset mid-frame discards all in-flight and buffered data and restores the identity kernel.
- i_start sampled at edge t: COMMIT during cycle t+1, STREAM (s_ready may be 1) from t+2.
- Word accepted at edge t: its result is sampled from i_conv_data at edge t+PIPE_LAT. m_valid rises after edge t+PIPE_LAT, so the result is available in cycle t+PIPE_LAT+1 when the FIFO was empty.
- o_sub_valid and o_sub_data are combinational from s_valid/s_data and registered state. s_ready depends only on registered state.
- o_done is high for exactly one cycle, the cycle DRAIN exits. o_busy falls in that same cycle. A new i_start is accepted the following cycle.

## Test plan
Parameter overrides for all scenarios: FRAME_WORDS=8, PRIME_WORDS=2, PIPE_LAT=2, FIFO_DEPTH=4.
- Reset: check identity kernel, o_kernel=72'h0000000007F00000000, all outputs 0. Assert reset mid-STREAM: state returns to IDLE and m_valid drops immediately.
- Full frame, m_ready=1, words 0..7, i_conv_data model = accepted word delayed 2 cycles: exactly 6 outputs equal to words 2..7 in order, then o_done pulses once.
- Back-pressure, m_ready=0 throughout: s_ready drops once fifo_count+pending=4. No result is lost. After m_ready is released, 6 outputs still arrive in order.
- Kernel load: write k=0 with 8'h11 during STREAM; o_kernel is unchanged until the next frame's COMMIT, then bits [7:0]=8'h11. A write to address 12 has no effect.
- Edge cases: i_start during STREAM is ignored. A kernel write coinciding with COMMIT is excluded from that frame. Simultaneous FIFO read and write at full keeps count 4 and preserves order.
